// File: rtl/rally_pkg.sv
// Shared types and constants for the rally controller: FSM encoding, court
// geometry and serve-state codes from the scorer.
package rally_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    FLIGHT = 2'd2,
    POINT  = 2'd3
  } rally_state_e;

  localparam int         N_POS     = 16;
  localparam logic [1:0] ST_P1     = 2'd0;
  localparam logic [1:0] ST_P2     = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;
  localparam logic [1:0] SPEED_MAX = 2'd3;

  // Codes 2 and 3 both mean the scorer has no serve pending.
  function automatic logic is_serve(input logic [1:0] st);
    return (st == ST_P1) || (st == ST_P2);
  endfunction

endpackage

// File: rtl/rally_ctrl_if.sv
// Scorer/player-facing signal bundle of the rally controller.
interface rally_ctrl_if;
  import rally_pkg::*;

  logic [1:0] st;
  logic       toIDLE;
  logic       kick;
  logic       hit1;
  logic       hit2;
  logic       win1;
  logic       win2;
  logic [3:0] ball_pos;
  logic       ball_dir;
  logic       busy;

  modport master (
    output st, toIDLE, kick, hit1, hit2,
    input  win1, win2, ball_pos, ball_dir, busy
  );

  modport slave (
    input  st, toIDLE, kick, hit1, hit2,
    output win1, win2, ball_pos, ball_dir, busy
  );

endinterface

// File: rtl/edge_det.sv
// Two-flop rising-edge detector for raw button levels; the pulse is a
// combination of registered history only.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic rise_o
);

  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= 2'b00;
    end else begin
      hist_q <= {hist_q[0], d_i};
    end
  end

  assign rise_o = hist_q[0] & ~hist_q[1];

endmodule

// File: rtl/rally_ctrl.sv
// Rally controller: serves the ball, steps it across a 16-position court,
// accepts paddle hits near each end and reports misses to the scorer.
module rally_ctrl
  import rally_pkg::*;
#(
  parameter int TICK_DIV = 8,
  parameter int HIT_WIN  = 2,
  parameter int HOLD     = 16
) (
  input  logic       clk,
  input  logic       reset,
  rally_ctrl_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int HW = $clog2(HOLD + 1);
  localparam logic [3:0] LO_EDGE = 4'(HIT_WIN - 1);
  localparam logic [3:0] HI_EDGE = 4'(N_POS - HIT_WIN);

  rally_state_e   state_q;
  logic [3:0]     ball_pos_q;
  logic           ball_dir_q;
  logic [1:0]     speed_q;
  logic [TW-1:0]  tick_cnt_q;
  logic [HW-1:0]  hold_cnt_q;
  logic           win1_q;
  logic           win2_q;
  logic           busy_q;

  logic [2:0] btn_raw;
  logic [2:0] btn_rise;
  logic       kick_rise;
  logic       hit_ok;
  logic       tick;
  logic [TW-1:0] period;

  assign btn_raw = {bus.hit2, bus.hit1, bus.kick};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
      edge_det u_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (btn_raw[gi]),
        .rise_o (btn_rise[gi])
      );
    end
  endgenerate

  assign kick_rise = btn_rise[0];

  // Only the paddle facing the incoming ball is evaluated.
  assign hit_ok = ball_dir_q ? (btn_rise[2] && (ball_pos_q >= HI_EDGE))
                             : (btn_rise[1] && (ball_pos_q <= LO_EDGE));

  always_comb begin
    period = TW'(TICK_DIV >> speed_q);
    if (period == '0) begin
      period = TW'(1);
    end
  end

  assign tick = (tick_cnt_q == period - 1'b1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ball_pos_q <= 4'd0;
      ball_dir_q <= 1'b0;
      speed_q    <= 2'd0;
      tick_cnt_q <= '0;
      hold_cnt_q <= '0;
      win1_q     <= 1'b0;
      win2_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      win1_q <= 1'b0;
      win2_q <= 1'b0;
      if (bus.toIDLE) begin
        state_q    <= IDLE;
        ball_pos_q <= 4'd0;
        ball_dir_q <= 1'b0;
        speed_q    <= 2'd0;
        tick_cnt_q <= '0;
        hold_cnt_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (is_serve(bus.st)) begin
              state_q    <= SERVE;
              busy_q     <= 1'b1;
              ball_pos_q <= (bus.st == ST_P1) ? 4'd0 : 4'(N_POS - 1);
              ball_dir_q <= (bus.st == ST_P1);
              speed_q    <= 2'd0;
            end
          end
          SERVE: begin
            if (!is_serve(bus.st)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else if (kick_rise) begin
              state_q    <= FLIGHT;
              tick_cnt_q <= '0;
            end
          end
          FLIGHT: begin
            // An accepted hit outranks a coincident tick, including a miss tick.
            if (hit_ok) begin
              ball_dir_q <= ~ball_dir_q;
              speed_q    <= (speed_q == SPEED_MAX) ? speed_q : speed_q + 2'd1;
              tick_cnt_q <= '0;
            end else if (tick) begin
              tick_cnt_q <= '0;
              if (!ball_dir_q && ball_pos_q == 4'd0) begin
                win2_q     <= 1'b1;
                state_q    <= POINT;
                hold_cnt_q <= '0;
              end else if (ball_dir_q && ball_pos_q == 4'(N_POS - 1)) begin
                win1_q     <= 1'b1;
                state_q    <= POINT;
                hold_cnt_q <= '0;
              end else begin
                ball_pos_q <= ball_dir_q ? ball_pos_q + 4'd1 : ball_pos_q - 4'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          POINT: begin
            if (hold_cnt_q == HW'(HOLD - 1)) begin
              if (is_serve(bus.st)) begin
                state_q    <= SERVE;
                ball_pos_q <= (bus.st == ST_P1) ? 4'd0 : 4'(N_POS - 1);
                ball_dir_q <= (bus.st == ST_P1);
                speed_q    <= 2'd0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.win1     = win1_q;
  assign bus.win2     = win2_q;
  assign bus.ball_pos = ball_pos_q;
  assign bus.ball_dir = ball_dir_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rally_ctrl.sv
// Directed bench for rally_ctrl: a per-cycle vector table for reset/serve
// behaviour, then hand-timed rallies for stepping, hits, misses and aborts.
module tb_rally_ctrl;
  import rally_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rally_ctrl_if bif();

  rally_ctrl #(.TICK_DIV(8), .HIT_WIN(2), .HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       rst_n;
    logic [1:0] st;
    logic       kick;
    logic       hit1;
    logic       hit2;
    logic       busy;
    logic [3:0] pos;
    logic       dir;
    logic       w1;
    logic       w2;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // which: 0 = kick, 1 = hit1, 2 = hit2; one cycle high then released
  task automatic press(input int which);
    case (which)
      0: bif.kick = 1'b1;
      1: bif.hit1 = 1'b1;
      default: bif.hit2 = 1'b1;
    endcase
    step();
    bif.kick = 1'b0;
    bif.hit1 = 1'b0;
    bif.hit2 = 1'b0;
    step();
  endtask

  task automatic measure_step(input int exp_cyc, input int exp_pos, input string name);
    logic [3:0] p0;
    int n;
    p0 = bif.ball_pos;
    n = 0;
    while (bif.ball_pos == p0 && n < 40) begin
      step();
      n++;
    end
    chk($sformatf("%s cycles", name), n, exp_cyc);
    chk($sformatf("%s pos", name), int'(bif.ball_pos), exp_pos);
  endtask

  task automatic wait_win(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(bif.win1 || bif.win2) && n < 400);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int ok;
    bif.st = 2'd2;
    bif.toIDLE = 1'b0;
    bif.kick = 1'b0;
    bif.hit1 = 1'b0;
    bif.hit2 = 1'b0;

    //          rst st kick h1 h2  busy pos dir w1 w2
    vecs[0] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      reset    = vecs[i].rst_n;
      bif.st   = vecs[i].st;
      bif.kick = vecs[i].kick;
      bif.hit1 = vecs[i].hit1;
      bif.hit2 = vecs[i].hit2;
      step();
      chk($sformatf("vec%0d busy", i), int'(bif.busy), int'(vecs[i].busy));
      chk($sformatf("vec%0d pos", i), int'(bif.ball_pos), int'(vecs[i].pos));
      chk($sformatf("vec%0d dir", i), int'(bif.ball_dir), int'(vecs[i].dir));
      chk($sformatf("vec%0d win1", i), int'(bif.win1), int'(vecs[i].w1));
      chk($sformatf("vec%0d win2", i), int'(bif.win2), int'(vecs[i].w2));
      $display("vec%0d busy=%0d pos=%0d dir=%0d", i, bif.busy, bif.ball_pos, bif.ball_dir);
    end

    // Serve from player 1 and let the ball run out at the far end.
    press(0);
    chk("A entry pos", int'(bif.ball_pos), 0);
    for (int k = 1; k <= 15; k++) measure_step(8, k, $sformatf("A step%0d", k));
    bif.st = 2'd1;
    wait_win(n);
    chk("A miss delay", n, 8);
    chk("A win1", int'(bif.win1), 1);
    chk("A win2", int'(bif.win2), 0);
    chk("A busy at point", int'(bif.busy), 1);
    ok = 1;
    for (int j = 1; j <= 15; j++) begin
      step();
      if (!bif.busy || bif.ball_dir !== 1'b1 || bif.win1 || bif.win2) ok = 0;
    end
    chk("A point hold", ok, 1);
    step();
    chk("A reserve pos", int'(bif.ball_pos), 15);
    chk("A reserve dir", int'(bif.ball_dir), 0);
    chk("A reserve busy", int'(bif.busy), 1);
    $display("A serve/miss done pass=%0d total=%0d", n_pass, n_total);

    // Returns with speed-up to saturation.
    press(0);
    for (int k = 0; k < 14; k++) measure_step(8, 14 - k, $sformatf("B down%0d", k));
    press(1);
    chk("B hit1 dir", int'(bif.ball_dir), 1);
    chk("B hit1 pos", int'(bif.ball_pos), 1);
    for (int k = 2; k <= 14; k++) measure_step(4, k, $sformatf("B s1 up%0d", k));
    press(2);
    chk("B hit2 dir", int'(bif.ball_dir), 0);
    for (int k = 13; k >= 1; k--) measure_step(2, k, $sformatf("B s2 down%0d", k));
    press(1);
    chk("B hit1b dir", int'(bif.ball_dir), 1);
    for (int k = 2; k <= 14; k++) measure_step(1, k, $sformatf("B s3 up%0d", k));
    press(2);
    chk("B edge hit dir", int'(bif.ball_dir), 0);
    chk("B edge hit pos", int'(bif.ball_pos), 15);
    chk("B edge hit no win", int'(bif.win1 | bif.win2), 0);
    measure_step(1, 14, "B saturated");
    press(2);
    chk("B wrong-dir hit2 dir", int'(bif.ball_dir), 0);
    chk("B wrong-dir hit2 pos", int'(bif.ball_pos), 12);
    wait_win(n);
    chk("B miss delay", n, 13);
    chk("B win2", int'(bif.win2), 1);
    chk("B win1", int'(bif.win1), 0);
    for (int j = 0; j < 16; j++) step();
    chk("B reserve pos", int'(bif.ball_pos), 15);
    chk("B reserve dir", int'(bif.ball_dir), 0);
    $display("B speed-up done pass=%0d total=%0d", n_pass, n_total);

    // Rejected hit out of window, hit colliding with miss tick, then abort.
    press(0);
    for (int k = 14; k >= 5; k--) measure_step(8, k, $sformatf("C down%0d", k));
    press(1);
    chk("C hit1@5 dir", int'(bif.ball_dir), 0);
    measure_step(6, 4, "C after reject");
    for (int k = 3; k >= 0; k--) measure_step(8, k, $sformatf("C down%0d", k));
    for (int j = 0; j < 6; j++) step();
    chk("C pre-collision pos", int'(bif.ball_pos), 0);
    bif.hit1 = 1'b1;
    step();
    bif.hit1 = 1'b0;
    step();
    chk("C collision dir", int'(bif.ball_dir), 1);
    chk("C collision win2", int'(bif.win2), 0);
    chk("C collision busy", int'(bif.busy), 1);
    for (int k = 1; k <= 7; k++) measure_step(4, k, $sformatf("C up%0d", k));
    bif.toIDLE = 1'b1;
    bif.st = 2'd2;
    step();
    bif.toIDLE = 1'b0;
    chk("C abort busy", int'(bif.busy), 0);
    chk("C abort pos", int'(bif.ball_pos), 0);
    chk("C abort dir", int'(bif.ball_dir), 0);
    chk("C abort wins", int'(bif.win1 | bif.win2), 0);
    step();
    chk("C stays idle", int'(bif.busy), 0);
    $display("C collision/abort done pass=%0d total=%0d", n_pass, n_total);

    // Serve withdrawn, then reset in the middle of POINT.
    bif.st = 2'd0;
    step();
    chk("D serve busy", int'(bif.busy), 1);
    bif.st = 2'd3;
    step();
    chk("D withdraw busy", int'(bif.busy), 0);
    bif.st = 2'd1;
    step();
    chk("D p2 serve pos", int'(bif.ball_pos), 15);
    chk("D p2 serve dir", int'(bif.ball_dir), 0);
    press(0);
    wait_win(n);
    chk("D miss delay", n, 128);
    chk("D win2", int'(bif.win2), 1);
    for (int j = 0; j < 5; j++) step();
    reset = 1'b0;
    bif.st = 2'd2;
    step();
    reset = 1'b1;
    chk("D reset busy", int'(bif.busy), 0);
    chk("D reset pos", int'(bif.ball_pos), 0);
    chk("D reset dir", int'(bif.ball_dir), 0);
    chk("D reset wins", int'(bif.win1 | bif.win2), 0);
    press(0);
    for (int j = 0; j < 4; j++) step();
    chk("D idle after kick busy", int'(bif.busy), 0);
    chk("D idle after kick pos", int'(bif.ball_pos), 0);
    $display("D reset-in-point done pass=%0d total=%0d", n_pass, n_total);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
